// File: rtl/ro_pkg.sv
// ro_pkg: shared helpers for the readout deserializer.
//   trailing_ones : saturating trailing-ones count; gives the gray bit that
//                   flips on cnt -> cnt+1, i.e. the channel owning that slot.
//   ch_width      : index width for n items, never below 1.
//   CH_W          : channel-index width for the default 8-channel build.
package ro_pkg;

    localparam int NCH_DEF = 8;
    localparam int CH_W    = $clog2(NCH_DEF);

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counts trailing ones of the low w bits of v, saturating at w-1 so the
    // all-ones count maps onto the top channel (the wrap back to 0).
    function automatic int trailing_ones(input logic [31:0] v, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && (i < w - 1) && v[i]) n = n + 1;
            else                            run = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/ro_fifo.sv
// ro_fifo: synchronous FIFO with full/empty flags, push and pop allowed in
// the same cycle (a push into a full FIFO is accepted when a pop frees the
// head entry on that edge).
//   clk_ext, rstb : clock, synchronous active-low reset
//   push, wdata   : write request and data
//   pop           : consume the head (ignored when empty)
//   rdata         : head entry, forced to 0 while empty
//   full, empty   : occupancy flags
module ro_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk_ext,
    input  logic         rstb,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_ext) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk_ext) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ro_deserializer.sv
// ro_deserializer: rebuilds the gray-counter slot schedule locally, steers
// each sample of the shared readout line to the channel owning the slot,
// packs WORD bits per channel and queues {ch, word} in a FIFO.
//   clk_ext, rstb       : master clock, synchronous active-low reset
//   en, sync            : advance enable, realign to gray counter reset
//   readout             : shared serial line (already synchronised)
//   out_valid/out_ready : head handshake; out_ch/out_word head contents
//   overflow            : sticky, set when a completed word is dropped
module ro_deserializer
    import ro_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int WORD       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_ext,
    input  logic                     rstb,
    input  logic                     en,
    input  logic                     sync,
    input  logic                     readout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ch_width(NCH)-1:0] out_ch,
    output logic [WORD-1:0]          out_word,
    output logic                     overflow
);
    localparam int CHW = ch_width(NCH);
    localparam int BCW = ch_width(WORD);
    localparam int EW  = CHW + WORD;

    logic [NCH-1:0]                cnt;
    logic [CHW-1:0]                slot;
    logic                          take;
    logic [NCH-1:0][WORD-1:0]      sreg;
    logic [NCH-1:0]                done;
    logic [WORD-1:0]               push_word;
    logic                          push, pop, full, empty;
    logic [EW-1:0]                 rdata;

    assign slot = CHW'(trailing_ones(32'(cnt), NCH));
    assign take = en & ~sync;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WORD-1:0] sreg_q;
        logic [BCW-1:0]  bitcnt_q;
        logic            hit;

        assign hit     = take && (slot == CHW'(c));
        assign done[c] = hit && (bitcnt_q == BCW'(WORD - 1));
        assign sreg[c] = sreg_q;

        always_ff @(posedge clk_ext) begin
            if (!rstb) begin
                sreg_q   <= '0;
                bitcnt_q <= '0;
            end else if (sync) begin
                bitcnt_q <= '0;
            end else if (hit) begin
                sreg_q[bitcnt_q] <= readout;
                bitcnt_q <= done[c] ? '0 : bitcnt_q + BCW'(1);
            end
        end
    end

    // The completing bit is still on the line; splice it in as the MSB.
    always_comb begin
        push_word           = sreg[slot];
        push_word[WORD-1]   = readout;
    end

    assign push      = |done;
    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign {out_ch, out_word} = rdata;

    always_ff @(posedge clk_ext) begin
        if (!rstb) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (sync)    cnt <= '0;
            else if (en) cnt <= cnt + NCH'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    ro_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_ext (clk_ext),
        .rstb    (rstb),
        .push    (push),
        .wdata   ({slot, push_word}),
        .pop     (pop),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty)
    );

endmodule
